i2c_master: RTL and testbench

// - Single-master I2C engine driven by the user_io I2C command registers (cmd 0x30 start, 0x31 poll).
// - Runs one register transaction per start pulse: write (addr, subaddr, data) or read (addr, subaddr -> 1 byte).
// - Returns result byte plus ack/end flags to user_io; drives open-drain SCL/SDA toward top-level pads (video encoder/codec config).

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_if.sv | 28 ++
 rtl/i2c_tick_gen.sv | 55 +++++
 rtl/i2c_master.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register-access master: FSM encoding, bit phases,
// R/W bit values and the latched request layout.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_TXBIT  = 4'd2;
    localparam logic [3:0] ST_TXACK  = 4'd3;
    localparam logic [3:0] ST_RSTART = 4'd4;
    localparam logic [3:0] ST_RXBIT  = 4'd5;
    localparam logic [3:0] ST_RXNACK = 4'd6;
    localparam logic [3:0] ST_STOP   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [1:0] BYTE_ADDR = 2'd0;
    localparam logic [1:0] BYTE_SUB  = 2'd1;
    localparam logic [1:0] BYTE_LAST = 2'd2;

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] subaddr;
        logic [7:0] dout;
    } i2c_req_t;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_if.sv
// Command/result handshake plus the open-drain SCL/SDA pad signals of the I2C master.
interface i2c_if;

    logic       i2c_start;
    logic       i2c_read;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_subaddr;
    logic [7:0] i2c_dout;
    logic [7:0] i2c_din;
    logic       i2c_ack;
    logic       i2c_end;
    logic       busy;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    modport master (
        input  i2c_start, i2c_read, i2c_addr, i2c_subaddr, i2c_dout, scl_i, sda_i,
        output i2c_din, i2c_ack, i2c_end, busy, scl_o, sda_o
    );

    modport slave (
        output i2c_start, i2c_read, i2c_addr, i2c_subaddr, i2c_dout, scl_i, sda_i,
        input  i2c_din, i2c_ack, i2c_end, busy, scl_o, sda_o
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator. While SCL is released but held low by a slave the
// tick is withheld and every would-be tick counts toward the stretch timeout instead.
module i2c_tick_gen #(
    parameter int CLK_DIV     = 63,
    parameter int STRETCH_MAX = 4095
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic run_i,
    input  logic freeze_i,
    output logic tick_o,
    output logic timeout_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int STR_W = $clog2(STRETCH_MAX + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [STR_W-1:0] str_q, str_d;
    logic             term;

    assign term      = run_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign tick_o    = term && !freeze_i;
    assign timeout_o = term && freeze_i && (str_q == STR_W'(STRETCH_MAX - 1));

    always_comb begin
        div_d = div_q;
        str_d = str_q;
        if (!run_i) begin
            div_d = '0;
            str_d = '0;
        end else if (term) begin
            div_d = '0;
            // Clearing on timeout lets the STOP sequence get its own stretch budget.
            if (!freeze_i || timeout_o) begin
                str_d = '0;
            end else begin
                str_d = str_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            str_q <= '0;
        end else begin
            div_q <= div_d;
            str_q <= str_d;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C register engine: one write (addr, subaddr, data) or read
// (addr, subaddr -> 1 byte) per start pulse, open-drain SCL/SDA outputs.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV     = 63,
    parameter int STRETCH_MAX = 4095
) (
    input  logic  clk_sys,
    input  logic  reset_n,
    i2c_if.master bus
);

    logic [3:0] state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] shift_q, shift_d;
    i2c_req_t   req_q, req_d;
    logic       nack_q, nack_d;
    logic       abort_q, abort_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic [7:0] din_q, din_d;
    logic       ack_q, ack_d;
    logic       end_q, end_d;
    logic       busy_q, busy_d;

    logic scl_meta_q, scl_sync_q;
    logic sda_meta_q, sda_sync_q;
    logic tick, timeout, freeze;

    assign freeze = scl_q && !scl_sync_q;

    i2c_tick_gen #(
        .CLK_DIV     (CLK_DIV),
        .STRETCH_MAX (STRETCH_MAX)
    ) u_tick_gen (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .run_i     (busy_q),
        .freeze_i  (freeze),
        .tick_o    (tick),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        req_d   = req_q;
        nack_d  = nack_q;
        abort_d = abort_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        din_d   = din_q;
        ack_d   = ack_q;
        end_d   = end_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i2c_start) begin
                    req_d   = {bus.i2c_read, bus.i2c_addr, bus.i2c_subaddr, bus.i2c_dout};
                    shift_d = addr_byte(bus.i2c_addr, RW_WRITE);
                    end_d   = 1'b0;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                    nack_d  = 1'b0;
                    abort_d = 1'b0;
                    bit_d   = '0;
                    byte_d  = BYTE_ADDR;
                    phase_d = PH0;
                    state_d = ST_START;
                end
            end

            ST_DONE: begin
                end_d = 1'b1;
                ack_d = !(nack_q || abort_q);
                if (req_q.rd && !nack_q && !abort_q) begin
                    din_d = shift_q;
                end
                busy_d  = 1'b0;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                phase_d = PH0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                if (timeout) begin
                    // A slave that never lets go of SCL in STOP must not wedge the engine.
                    abort_d = 1'b1;
                    phase_d = PH0;
                    state_d = (state_q == ST_STOP) ? ST_DONE : ST_STOP;
                end else if (tick) begin
                    phase_d = phase_q + 2'd1;
                    case (state_q)
                        ST_START: begin
                            case (phase_q)
                                PH0: sda_d = 1'b0;
                                PH2: begin
                                    scl_d   = 1'b0;
                                    phase_d = PH0;
                                    state_d = ST_TXBIT;
                                end
                                default: ;
                            endcase
                        end

                        ST_TXBIT: begin
                            case (phase_q)
                                PH0: sda_d = shift_q[7];
                                PH1: scl_d = 1'b1;
                                PH3: begin
                                    scl_d   = 1'b0;
                                    shift_d = {shift_q[6:0], 1'b0};
                                    bit_d   = bit_q + 3'd1;
                                    if (bit_q == 3'd7) state_d = ST_TXACK;
                                end
                                default: ;
                            endcase
                        end

                        ST_TXACK: begin
                            case (phase_q)
                                PH0: sda_d  = 1'b1;
                                PH1: scl_d  = 1'b1;
                                PH2: nack_d = sda_sync_q;
                                PH3: begin
                                    scl_d = 1'b0;
                                    if (byte_q != 2'd3) byte_d = byte_q + 2'd1;
                                    if (nack_q) begin
                                        state_d = ST_STOP;
                                    end else if (byte_q == BYTE_ADDR) begin
                                        shift_d = req_q.subaddr;
                                        state_d = ST_TXBIT;
                                    end else if (byte_q == BYTE_SUB) begin
                                        if (req_q.rd) begin
                                            shift_d = addr_byte(req_q.addr, RW_READ);
                                            state_d = ST_RSTART;
                                        end else begin
                                            shift_d = req_q.dout;
                                            state_d = ST_TXBIT;
                                        end
                                    end else begin
                                        state_d = req_q.rd ? ST_RXBIT : ST_STOP;
                                    end
                                end
                                default: ;
                            endcase
                        end

                        ST_RSTART: begin
                            case (phase_q)
                                PH0: sda_d = 1'b1;
                                PH1: scl_d = 1'b1;
                                PH2: sda_d = 1'b0;
                                PH3: begin
                                    scl_d   = 1'b0;
                                    state_d = ST_TXBIT;
                                end
                                default: ;
                            endcase
                        end

                        ST_RXBIT: begin
                            case (phase_q)
                                PH0: sda_d   = 1'b1;
                                PH1: scl_d   = 1'b1;
                                PH2: shift_d = {shift_q[6:0], sda_sync_q};
                                PH3: begin
                                    scl_d = 1'b0;
                                    bit_d = bit_q + 3'd1;
                                    if (bit_q == 3'd7) state_d = ST_RXNACK;
                                end
                                default: ;
                            endcase
                        end

                        ST_RXNACK: begin
                            case (phase_q)
                                PH0: sda_d = 1'b1;
                                PH1: scl_d = 1'b1;
                                PH3: begin
                                    scl_d   = 1'b0;
                                    state_d = ST_STOP;
                                end
                                default: ;
                            endcase
                        end

                        ST_STOP: begin
                            case (phase_q)
                                PH0: begin
                                    scl_d = 1'b0;
                                    sda_d = 1'b0;
                                end
                                PH1: scl_d = 1'b1;
                                PH2: begin
                                    sda_d   = 1'b1;
                                    phase_d = PH0;
                                    state_d = ST_DONE;
                                end
                                default: ;
                            endcase
                        end

                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH0;
            bit_q      <= '0;
            byte_q     <= BYTE_ADDR;
            shift_q    <= '0;
            req_q      <= '0;
            nack_q     <= 1'b0;
            abort_q    <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            din_q      <= '0;
            ack_q      <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            req_q      <= req_d;
            nack_q     <= nack_d;
            abort_q    <= abort_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            din_q      <= din_d;
            ack_q      <= ack_d;
            end_q      <= end_d;
            busy_q     <= busy_d;
            scl_meta_q <= bus.scl_i;
            scl_sync_q <= scl_meta_q;
            sda_meta_q <= bus.sda_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign bus.scl_o   = scl_q;
    assign bus.sda_o   = sda_q;
    assign bus.i2c_din = din_q;
    assign bus.i2c_ack = ack_q;
    assign bus.i2c_end = end_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus with a behavioural slave, bus event monitor and a
// transaction-level reference model; directed cases followed by randomized transactions.
module tb_i2c_master;

    localparam int CLK_DIV     = 4;
    localparam int STRETCH_MAX = 8;
    localparam int EV_S        = 256;
    localparam int EV_P        = 512;
    localparam int MAX_CYC     = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_if ifc();

    logic s_scl = 1'b1;
    logic s_sda = 1'b1;
    assign ifc.scl_i = ifc.scl_o & s_scl;
    assign ifc.sda_i = ifc.sda_o & s_sda;

    i2c_master #(
        .CLK_DIV     (CLK_DIV),
        .STRETCH_MAX (STRETCH_MAX)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (ifc.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs and observed bus events.
    int         mon_q[$];
    logic       nack_addr    = 1'b0;
    logic [7:0] txd          = 8'h00;
    int         stretch_byte = 0;
    int         stretch_cyc  = 0;

    initial begin : slave_bfm
        int         bitn, byte_cnt, stretch_left;
        logic [7:0] sh;
        logic       tx, rd_pending, prev_scl, prev_sda, cs, cd, ackb;
        bitn = -1; byte_cnt = 0; stretch_left = 0; sh = 8'h00;
        tx = 1'b0; rd_pending = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_scl = 1'b1; s_sda = 1'b1; bitn = -1; tx = 1'b0; rd_pending = 1'b0;
                byte_cnt = 0; stretch_left = 0; prev_scl = 1'b1; prev_sda = 1'b1;
            end else begin
                cs = ifc.scl_i;
                cd = ifc.sda_i;
                if (stretch_left > 0) begin
                    stretch_left--;
                    if (stretch_left == 0) s_scl = 1'b1;
                end
                if (prev_scl && cs && prev_sda && !cd) begin
                    mon_q.push_back(EV_S);
                    bitn = -1; tx = 1'b0; rd_pending = 1'b0; byte_cnt = 0; s_sda = 1'b1;
                end else if (prev_scl && cs && !prev_sda && cd) begin
                    mon_q.push_back(EV_P);
                    bitn = -1; tx = 1'b0; rd_pending = 1'b0; s_sda = 1'b1;
                end else if (!prev_scl && cs) begin
                    if (bitn >= 0 && bitn < 8 && !tx) sh = {sh[6:0], cd};
                end else if (prev_scl && !cs) begin
                    bitn++;
                    if (bitn == 8) begin
                        if (tx) begin
                            s_sda = 1'b1;
                        end else begin
                            mon_q.push_back(int'(sh));
                            ackb = !(byte_cnt == 0 && nack_addr);
                            s_sda = !ackb;
                            if (byte_cnt == 0) rd_pending = sh[0] && ackb;
                        end
                    end else if (bitn == 9) begin
                        bitn = 0;
                        byte_cnt++;
                        s_sda = 1'b1;
                        if (rd_pending) begin
                            tx = 1'b1;
                            rd_pending = 1'b0;
                            s_sda = txd[7];
                        end else begin
                            tx = 1'b0;
                        end
                    end else if (tx && bitn >= 1 && bitn <= 7) begin
                        s_sda = txd[7-bitn];
                    end
                    if (bitn == 3 && byte_cnt == stretch_byte && stretch_cyc > 0) begin
                        s_scl = 1'b0;
                        stretch_left = stretch_cyc;
                        stretch_cyc = 0;
                    end
                end
                prev_scl = cs;
                prev_sda = cd;
            end
        end
    end

    logic [7:0] model_din = 8'h00;
    int         txn_no = 0;

    task automatic run_txn(input logic rd, input logic [6:0] a, input logic [7:0] sa,
                           input logic [7:0] d, input logic [7:0] sd, input logic nk,
                           input int st_cyc, input logic abort_exp, input logic inject);
        int         expq[$];
        int         ticks, cyc;
        logic       exp_ack;
        logic [7:0] exp_din;
        // Reference model: bus event sequence, nominal tick count and result registers.
        expq.push_back(EV_S);
        expq.push_back(int'({a, 1'b0}));
        if (nk) begin
            expq.push_back(EV_P);
        end else begin
            expq.push_back(int'(sa));
            if (!rd) begin
                expq.push_back(int'(d));
            end else begin
                expq.push_back(EV_S);
                expq.push_back(int'({a, 1'b1}));
            end
            expq.push_back(EV_P);
        end
        ticks   = nk ? (3 + 36 + 3) : (rd ? (3 + 72 + 4 + 36 + 32 + 4 + 3) : (3 + 108 + 3));
        exp_ack = !nk && !abort_exp;
        exp_din = (rd && !nk && !abort_exp) ? sd : model_din;
        model_din = exp_din;

        nack_addr = nk; txd = sd; stretch_byte = 1; stretch_cyc = st_cyc;
        mon_q.delete();
        @(negedge clk);
        ifc.i2c_read = rd; ifc.i2c_addr = a; ifc.i2c_subaddr = sa; ifc.i2c_dout = d;
        ifc.i2c_start = 1'b1;
        @(negedge clk);
        ifc.i2c_start = 1'b0;
        chk("busy_after_start", ifc.busy, 1'b1);
        chk("end_cleared", ifc.i2c_end, 1'b0);
        cyc = 0;
        while (cyc < MAX_CYC && !(ifc.i2c_end && !ifc.busy)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 60) begin
                ifc.i2c_start = 1'b1; ifc.i2c_addr = ~a; ifc.i2c_read = ~rd; ifc.i2c_dout = ~d;
            end else if (inject && cyc == 61) begin
                ifc.i2c_start = 1'b0;
            end
        end
        chk("done_in_time", cyc < MAX_CYC, 1'b1);
        if (!abort_exp && st_cyc == 0)
            chk("latency", (cyc >= ticks * CLK_DIV) && (cyc <= ticks * CLK_DIV + 3), 1'b1);
        if (!abort_exp && st_cyc > 0)
            chk("stretch_delays", cyc > ticks * CLK_DIV + 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("ack", ifc.i2c_ack, exp_ack);
        chk("end", ifc.i2c_end, 1'b1);
        chk("busy_idle", ifc.busy, 1'b0);
        chk("din", ifc.i2c_din, exp_din);
        chk("scl_released", ifc.scl_o, 1'b1);
        chk("sda_released", ifc.sda_o, 1'b1);
        if (!abort_exp) begin
            chk("ev_count", mon_q.size(), expq.size());
            for (int i = 0; i < expq.size() && i < mon_q.size(); i++)
                chk($sformatf("ev%0d", i), mon_q[i], expq[i]);
        end
        $display("txn %0d: %s addr=0x%02h sub=0x%02h data=0x%02h slv_nack=%0d stretch=%0d -> ack=%0d end=%0d din=0x%02h cycles=%0d",
                 txn_no, rd ? "RD" : "WR", a, sa, rd ? sd : d, nk, st_cyc,
                 ifc.i2c_ack, ifc.i2c_end, ifc.i2c_din, cyc);
        txn_no++;
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        logic       rd, nk;
        logic [6:0] a;
        logic [7:0] sa, d, sd;
        ifc.i2c_start = 1'b0; ifc.i2c_read = 1'b0; ifc.i2c_addr = '0;
        ifc.i2c_subaddr = '0; ifc.i2c_dout = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", ifc.scl_o, 1'b1);
        chk("rst_sda", ifc.sda_o, 1'b1);
        chk("rst_din", ifc.i2c_din, 8'h00);
        chk("rst_ack", ifc.i2c_ack, 1'b0);
        chk("rst_end", ifc.i2c_end, 1'b0);
        chk("rst_busy", ifc.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b0, 7'h1A, 8'h05, 8'hA5, 8'h00, 1'b0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 7'h1A, 8'h10, 8'h00, 8'h5C, 1'b0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 7'h1A, 8'h22, 8'h33, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        run_txn(1'b0, 7'h2B, 8'h44, 8'h96, 8'h00, 1'b0, 20, 1'b0, 1'b0);
        run_txn(1'b0, 7'h2B, 8'h45, 8'h69, 8'h00, 1'b0, 70, 1'b1, 1'b0);
        run_txn(1'b1, 7'h4C, 8'h7E, 8'h00, 8'hC3, 1'b0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the address byte.
        @(negedge clk);
        ifc.i2c_read = 1'b0; ifc.i2c_addr = 7'h55; ifc.i2c_subaddr = 8'h01; ifc.i2c_dout = 8'h02;
        ifc.i2c_start = 1'b1;
        @(negedge clk);
        ifc.i2c_start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", ifc.scl_o, 1'b1);
        chk("midrst_sda", ifc.sda_o, 1'b1);
        chk("midrst_end", ifc.i2c_end, 1'b0);
        chk("midrst_busy", ifc.busy, 1'b0);
        chk("midrst_din", ifc.i2c_din, 8'h00);
        model_din = 8'h00;
        $display("txn %0d: reset asserted mid-byte -> scl=%0d sda=%0d busy=%0d end=%0d",
                 txn_no, ifc.scl_o, ifc.sda_o, ifc.busy, ifc.i2c_end);
        txn_no++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            rd = 1'($urandom_range(0, 1));
            nk = ($urandom_range(0, 3) == 0);
            a  = 7'($urandom);
            sa = 8'($urandom);
            d  = 8'($urandom);
            sd = 8'($urandom);
            run_txn(rd, a, sa, d, sd, nk, 0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
